sc_phase_generator: RTL

//  Two-phase non-overlapping clock generator that drives phi1/phi2 of the switched-capacitor filter.

---
 rtl/sc_phase_pkg.sv | 20 ++
 rtl/sc_phase_generator_if.sv | 34 +++
 rtl/sc_phase_counter.sv | 37 +++
 rtl/sc_phase_generator.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/sc_phase_pkg.sv
// Shared types and helpers for the two-phase non-overlapping clock generator.
package sc_phase_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        P1   = 3'd1,
        D12  = 3'd2,
        P2   = 3'd3,
        D21  = 3'd4
    } phase_state_t;

    localparam int unsigned DEF_PHI_LEN = 4;
    localparam int unsigned DEF_DEAD    = 1;

    // Raise a programmed length to a minimum value.
    function automatic int unsigned clamp_len(input int unsigned len, input int unsigned floor_len);
        return (len < floor_len) ? floor_len : len;
    endfunction

endpackage

// File: rtl/sc_phase_generator_if.sv
// Configuration/phase bus of the phase generator.
// Optional early phases phi1e/phi2e exist only when SC_PHASE_GEN_EARLY_EN is defined.
interface sc_phase_generator_if #(
    parameter int unsigned CNT_W = 5
);
    logic             en;
    logic [CNT_W-1:0] phi1_len;
    logic [CNT_W-1:0] phi2_len;
    logic [CNT_W-1:0] dead_len;
    logic             phi1;
    logic             phi2;
    logic             frame_done;
    logic             busy;
`ifdef SC_PHASE_GEN_EARLY_EN
    logic             phi1e;
    logic             phi2e;
`endif

    modport master (
        output en, phi1_len, phi2_len, dead_len,
`ifdef SC_PHASE_GEN_EARLY_EN
        input  phi1e, phi2e,
`endif
        input  phi1, phi2, frame_done, busy
    );

    modport slave (
        input  en, phi1_len, phi2_len, dead_len,
`ifdef SC_PHASE_GEN_EARLY_EN
        output phi1e, phi2e,
`endif
        output phi1, phi2, frame_done, busy
    );
endinterface

// File: rtl/sc_phase_counter.sv
// Loadable down-counter that saturates at zero; flags current and next-cycle zero.
module sc_phase_counter #(
    parameter int unsigned CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             zero_c,
    output logic             next_zero_c
);
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Load takes priority; otherwise decrement without wrapping below zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    // Counter register with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_c      = (cnt_q == '0);
    assign next_zero_c = (cnt_d == '0);

endmodule

// File: rtl/sc_phase_generator.sv
// Two-phase non-overlapping clock generator (phi1/phi2) with programmable
// high and dead times and a per-period frame strobe.
// Define SC_PHASE_GEN_EARLY_EN to add early phases phi1e/phi2e.
module sc_phase_generator
    import sc_phase_pkg::*;
#(
    parameter int unsigned CNT_W    = 5,
    parameter int unsigned MIN_DEAD = DEF_DEAD
) (
    input  logic                clk,
    input  logic                rst_n,
    sc_phase_generator_if.slave bus
);
    phase_state_t     state_q, state_d;
    logic [CNT_W-1:0] eff_p2_q, eff_p2_d;
    logic [CNT_W-1:0] eff_d_q, eff_d_d;
    logic [CNT_W-1:0] eff_p1_c, eff_p2_c, eff_d_c;
    logic             cnt_load;
    logic [CNT_W-1:0] cnt_load_val;
    logic             zero_c, next_zero_c;
    logic             phi1_q, phi1_d;
    logic             phi2_q, phi2_d;
    logic             frame_done_q, frame_done_d;
    logic             busy_q, busy_d;
`ifdef SC_PHASE_GEN_EARLY_EN
    logic             phi1e_q, phi1e_d;
    logic             phi2e_q, phi2e_d;
`endif

    // Effective lengths as they would be latched this cycle.
    assign eff_p1_c = CNT_W'(clamp_len(32'(bus.phi1_len), 32'd1));
    assign eff_p2_c = CNT_W'(clamp_len(32'(bus.phi2_len), 32'd1));
    assign eff_d_c  = CNT_W'(clamp_len(32'(bus.dead_len), MIN_DEAD));

    sc_phase_counter #(.CNT_W(CNT_W)) u_cnt (
        .clk         (clk),
        .rst_n       (rst_n),
        .load        (cnt_load),
        .load_val    (cnt_load_val),
        .zero_c      (zero_c),
        .next_zero_c (next_zero_c)
    );

    // State, latched configuration and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            eff_p2_q     <= '0;
            eff_d_q      <= '0;
            phi1_q       <= 1'b0;
            phi2_q       <= 1'b0;
            frame_done_q <= 1'b0;
            busy_q       <= 1'b0;
`ifdef SC_PHASE_GEN_EARLY_EN
            phi1e_q      <= 1'b0;
            phi2e_q      <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            eff_p2_q     <= eff_p2_d;
            eff_d_q      <= eff_d_d;
            phi1_q       <= phi1_d;
            phi2_q       <= phi2_d;
            frame_done_q <= frame_done_d;
            busy_q       <= busy_d;
`ifdef SC_PHASE_GEN_EARLY_EN
            phi1e_q      <= phi1e_d;
            phi2e_q      <= phi2e_d;
`endif
        end
    end

    // Next state, counter reloads and configuration latch at each period start.
    always_comb begin
        state_d      = state_q;
        eff_p2_d     = eff_p2_q;
        eff_d_d      = eff_d_q;
        cnt_load     = 1'b0;
        cnt_load_val = '0;
        case (state_q)
            IDLE: begin
                if (bus.en) begin
                    state_d      = P1;
                    eff_p2_d     = eff_p2_c;
                    eff_d_d      = eff_d_c;
                    cnt_load     = 1'b1;
                    cnt_load_val = eff_p1_c - CNT_W'(1);
                end
            end
            P1: begin
                if (zero_c) begin
                    state_d      = D12;
                    cnt_load     = 1'b1;
                    cnt_load_val = eff_d_q - CNT_W'(1);
                end
            end
            D12: begin
                if (zero_c) begin
                    state_d      = P2;
                    cnt_load     = 1'b1;
                    cnt_load_val = eff_p2_q - CNT_W'(1);
                end
            end
            P2: begin
                if (zero_c) begin
                    state_d      = D21;
                    cnt_load     = 1'b1;
                    cnt_load_val = eff_d_q - CNT_W'(1);
                end
            end
            D21: begin
                if (zero_c) begin
                    if (bus.en) begin
                        state_d      = P1;
                        eff_p2_d     = eff_p2_c;
                        eff_d_d      = eff_d_c;
                        cnt_load     = 1'b1;
                        cnt_load_val = eff_p1_c - CNT_W'(1);
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output decode of the upcoming state so every output is a flop.
    always_comb begin
        phi1_d       = (state_d == P1);
        phi2_d       = (state_d == P2);
        frame_done_d = (state_d == D21) && next_zero_c;
        busy_d       = (state_d != IDLE);
`ifdef SC_PHASE_GEN_EARLY_EN
        phi1e_d      = (state_d == P1) && !next_zero_c;
        phi2e_d      = (state_d == P2) && !next_zero_c;
`endif
    end

    assign bus.phi1       = phi1_q;
    assign bus.phi2       = phi2_q;
    assign bus.frame_done = frame_done_q;
    assign bus.busy       = busy_q;
`ifdef SC_PHASE_GEN_EARLY_EN
    assign bus.phi1e      = phi1e_q;
    assign bus.phi2e      = phi2e_q;
`endif

endmodule
